// File: rtl/acc_io_port_if.sv
// acc_io_port_if
//   Bundles the handshake and data signals of the accumulator machine's
//   memory-mapped I/O port. The slave modport is the port itself; the
//   master modport is whatever drives it (external producer/sink plus the
//   CPU control and memory stage).
//
//   Input side  : ExtInData/ExtInValid/ExtInReady (external producer),
//                 IORead/IOIn/IOInAvail/InCount   (CPU consumer)
//   Output side : IOOut/IOWrite                   (CPU producer),
//                 ExtOutData/ExtOutValid/ExtOutReady (external sink)
//   Status      : Overrun/Underrun sticky flags, ClearErr clears both
interface acc_io_port_if #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH_LOG2 = 2
);
  logic [DATA_WIDTH-1:0] ExtInData;
  logic                  ExtInValid;
  logic                  ExtInReady;
  logic                  IORead;
  logic [DATA_WIDTH-1:0] IOIn;
  logic                  IOInAvail;
  logic [DEPTH_LOG2:0]   InCount;
  logic [DATA_WIDTH-1:0] IOOut;
  logic                  IOWrite;
  logic [DATA_WIDTH-1:0] ExtOutData;
  logic                  ExtOutValid;
  logic                  ExtOutReady;
  logic                  Overrun;
  logic                  Underrun;
  logic                  ClearErr;

  // The I/O port block itself.
  modport slave (
    input  ExtInData, ExtInValid, IORead, IOOut, IOWrite, ExtOutReady, ClearErr,
    output ExtInReady, IOIn, IOInAvail, InCount, ExtOutData, ExtOutValid,
           Overrun, Underrun
  );

  // Everything surrounding the port: external world, control and memory stage.
  modport master (
    output ExtInData, ExtInValid, IORead, IOOut, IOWrite, ExtOutReady, ClearErr,
    input  ExtInReady, IOIn, IOInAvail, InCount, ExtOutData, ExtOutValid,
           Overrun, Underrun
  );
endinterface

// File: rtl/acc_io_port.sv
// acc_io_port
//   Memory-mapped I/O port of the 16-bit accumulator machine.
//   Input side : a small circular FIFO buffers external words; the head word
//                is presented combinationally on IOIn (zero when empty) and
//                popped by a one-cycle IORead pulse from control.
//   Output side: a two-state IDLE/HOLD register captures IOOut on IOWrite and
//                offers it to the external sink with a ready/valid handshake.
//   Errors     : Overrun (IOWrite dropped while HOLD is blocked) and Underrun
//                (IORead with FIFO empty) are sticky until ClearErr.
//
// Ports
//   CLK   : single rising-edge clock
//   Reset : asynchronous, active-low; clears pointers, count, output
//           register, FSM and flags
//   bus   : acc_io_port_if slave modport carrying all data/handshake signals
module acc_io_port #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH_LOG2 = 2
) (
  input logic           CLK,
  input logic           Reset,
  acc_io_port_if.slave  bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [DEPTH_LOG2:0]   count_t;

  localparam ptr_t   PTR_ONE    = ptr_t'(1);
  localparam count_t COUNT_ONE  = count_t'(1);
  localparam count_t COUNT_FULL = count_t'(DEPTH);

  typedef enum logic {
    OUT_IDLE = 1'b0,
    OUT_HOLD = 1'b1
  } out_state_t;

  // ------------------------------------------------------------------
  // Input FIFO state
  // ------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  ptr_t                  wr_ptr_q;
  ptr_t                  rd_ptr_q;
  count_t                count_q;

  logic fifo_full;
  logic fifo_empty;
  logic push;
  logic pop;
  logic underrun_evt;

  assign fifo_full  = (count_q == COUNT_FULL);
  assign fifo_empty = (count_q == '0);

  // A pop frees a slot only after the edge, so a full FIFO refuses the
  // producer even when a pop happens in the same cycle.
  assign push         = bus.ExtInValid & ~fifo_full;
  assign pop          = bus.IORead & ~fifo_empty;
  assign underrun_evt = bus.IORead & fifo_empty;

  // Pointers and occupancy. Simultaneous push and pop leave the count alone.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      if (push && !pop) begin
        count_q <= count_q + COUNT_ONE;
      end else if (pop && !push) begin
        count_q <= count_q - COUNT_ONE;
      end
    end
  end

  // Storage needs no reset: stale words are never visible because IOIn is
  // gated while the FIFO is empty and the pointers restart at zero.
  always_ff @(posedge CLK) begin
    if (Reset && push) begin
      mem[wr_ptr_q] <= bus.ExtInData;
    end
  end

  assign bus.ExtInReady = ~fifo_full;
  assign bus.IOInAvail  = ~fifo_empty;
  assign bus.IOIn       = fifo_empty ? '0 : mem[rd_ptr_q];
  assign bus.InCount    = count_q;

  // ------------------------------------------------------------------
  // Output handoff register
  // ------------------------------------------------------------------
  out_state_t            out_state_q;
  out_state_t            out_state_d;
  logic                  out_load;
  logic                  overrun_evt;
  logic [DATA_WIDTH-1:0] out_data_q;

  // IDLE accepts any IOWrite. HOLD accepts a new word only when the sink
  // takes the current one on the same edge; otherwise the write is dropped
  // and reported as an overrun.
  always_comb begin
    out_state_d = out_state_q;
    out_load    = 1'b0;
    overrun_evt = 1'b0;
    case (out_state_q)
      OUT_IDLE: begin
        if (bus.IOWrite) begin
          out_load    = 1'b1;
          out_state_d = OUT_HOLD;
        end
      end
      OUT_HOLD: begin
        if (bus.ExtOutReady) begin
          if (bus.IOWrite) begin
            out_load    = 1'b1;
            out_state_d = OUT_HOLD;
          end else begin
            out_state_d = OUT_IDLE;
          end
        end else if (bus.IOWrite) begin
          overrun_evt = 1'b1;
        end
      end
      default: begin
        out_state_d = OUT_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      out_state_q <= OUT_IDLE;
      out_data_q  <= '0;
    end else begin
      out_state_q <= out_state_d;
      if (out_load) begin
        out_data_q <= bus.IOOut;
      end
    end
  end

  assign bus.ExtOutData  = out_data_q;
  assign bus.ExtOutValid = (out_state_q == OUT_HOLD);

  // ------------------------------------------------------------------
  // Sticky error flags: a fresh event in the ClearErr cycle wins.
  // ------------------------------------------------------------------
  logic overrun_q;
  logic underrun_q;
  logic overrun_d;
  logic underrun_d;

  always_comb begin
    overrun_d  = overrun_q;
    underrun_d = underrun_q;
    if (bus.ClearErr) begin
      overrun_d  = 1'b0;
      underrun_d = 1'b0;
    end
    if (overrun_evt) begin
      overrun_d = 1'b1;
    end
    if (underrun_evt) begin
      underrun_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      overrun_q  <= overrun_d;
      underrun_q <= underrun_d;
    end
  end

  assign bus.Overrun  = overrun_q;
  assign bus.Underrun = underrun_q;

endmodule

// File: tb/tb_acc_io_port.sv
// tb_acc_io_port
//   Directed bench for acc_io_port. Inputs change 1 ns after each rising
//   edge and outputs are sampled at the same point, well clear of the edge.
module tb_acc_io_port;

  logic CLK;
  logic Reset;

  int check_count;
  int error_count;

  acc_io_port_if #(.DATA_WIDTH(16), .DEPTH_LOG2(2)) bus ();

  acc_io_port #(.DATA_WIDTH(16), .DEPTH_LOG2(2)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  // 10 ns clock
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", tag, actual, expected);
    end
  endtask

  // Advance one clock and settle 1 ns past the edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Drive one cycle's worth of inputs, then clock it in.
  task automatic applyStimulus(input logic in_valid, input logic [15:0] in_data,
                               input logic rd, input logic wr,
                               input logic [15:0] out_word, input logic out_ready,
                               input logic clr);
    bus.ExtInValid  = in_valid;
    bus.ExtInData   = in_data;
    bus.IORead      = rd;
    bus.IOWrite     = wr;
    bus.IOOut       = out_word;
    bus.ExtOutReady = out_ready;
    bus.ClearErr    = clr;
    step();
  endtask

  task automatic idle();
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
  endtask

  logic [15:0] fill_words [4];
  logic [15:0] pop_expect [4];

  initial begin
    check_count = 0;
    error_count = 0;
    fill_words  = '{16'h1234, 16'hABCD, 16'h0F0F, 16'h5555};
    pop_expect  = '{16'hABCD, 16'h0F0F, 16'h5555, 16'h0000};

    Reset           = 1'b0;
    bus.ExtInValid  = 1'b0;
    bus.ExtInData   = '0;
    bus.IORead      = 1'b0;
    bus.IOWrite     = 1'b0;
    bus.IOOut       = '0;
    bus.ExtOutReady = 1'b0;
    bus.ClearErr    = 1'b0;

    // Reset state
    step();
    step();
    checkOutput("rst_incount",  32'(bus.InCount), 32'd0);
    checkOutput("rst_avail",    32'(bus.IOInAvail), 32'd0);
    checkOutput("rst_ioin",     32'(bus.IOIn), 32'h0);
    checkOutput("rst_outvalid", 32'(bus.ExtOutValid), 32'd0);
    checkOutput("rst_outdata",  32'(bus.ExtOutData), 32'h0);
    checkOutput("rst_overrun",  32'(bus.Overrun), 32'd0);
    checkOutput("rst_underrun", 32'(bus.Underrun), 32'd0);
    Reset = 1'b1;
    step();
    checkOutput("rel_inready", 32'(bus.ExtInReady), 32'd1);

    // Fill the FIFO; first word visible one cycle after its push
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, fill_words[i], 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
      if (i == 0) begin
        checkOutput("first_ioin", 32'(bus.IOIn), 32'h1234);
      end
    end
    checkOutput("full_count",   32'(bus.InCount), 32'd4);
    checkOutput("full_inready", 32'(bus.ExtInReady), 32'd0);
    applyStimulus(1'b1, 16'hDEAD, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    checkOutput("full_reject_count", 32'(bus.InCount), 32'd4);
    checkOutput("full_head",         32'(bus.IOIn), 32'h1234);

    // Drain from full
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
      checkOutput($sformatf("drain_ioin%0d", i), 32'(bus.IOIn), 32'(pop_expect[i]));
      if (i == 0) begin
        checkOutput("drain_inready", 32'(bus.ExtInReady), 32'd1);
      end
    end
    checkOutput("drain_avail",    32'(bus.IOInAvail), 32'd0);
    checkOutput("drain_underrun", 32'(bus.Underrun), 32'd0);

    // Wrap-around with simultaneous push/pop at count 1
    applyStimulus(1'b1, 16'h1000, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 16'h2000 + 16'(i), 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
      checkOutput($sformatf("wrap_count%0d", i), 32'(bus.InCount), 32'd1);
      checkOutput($sformatf("wrap_ioin%0d", i), 32'(bus.IOIn), 32'h2000 + i);
    end
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    checkOutput("wrap_drained", 32'(bus.InCount), 32'd0);

    // Underrun with simultaneous push
    applyStimulus(1'b1, 16'h7777, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    checkOutput("ur_flag",  32'(bus.Underrun), 32'd1);
    checkOutput("ur_count", 32'(bus.InCount), 32'd1);
    checkOutput("ur_ioin",  32'(bus.IOIn), 32'h7777);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    checkOutput("ur_clear", 32'(bus.Underrun), 32'd0);
    checkOutput("ur_keep",  32'(bus.IOIn), 32'h7777);
    // Pop the 7777, then read empty while clearing: the set must win
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    checkOutput("ur_noflag", 32'(bus.Underrun), 32'd0);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
    checkOutput("ur_setwins", 32'(bus.Underrun), 32'd1);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    checkOutput("ur_clear2", 32'(bus.Underrun), 32'd0);

    // Output side
    checkOutput("out_idle", 32'(bus.ExtOutValid), 32'd0);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b1, 16'h00A5, 1'b0, 1'b0);
    checkOutput("out_valid1", 32'(bus.ExtOutValid), 32'd1);
    checkOutput("out_data1",  32'(bus.ExtOutData), 32'h00A5);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b1, 16'h005A, 1'b0, 1'b0);
    checkOutput("ovr_data", 32'(bus.ExtOutData), 32'h00A5);
    checkOutput("ovr_flag", 32'(bus.Overrun), 32'd1);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b1, 16'h0123, 1'b1, 1'b0);
    checkOutput("b2b_data",  32'(bus.ExtOutData), 32'h0123);
    checkOutput("b2b_valid", 32'(bus.ExtOutValid), 32'd1);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    checkOutput("drain_valid",  32'(bus.ExtOutValid), 32'd0);
    checkOutput("drain_data",   32'(bus.ExtOutData), 32'h0123);
    checkOutput("ovr_sticky",   32'(bus.Overrun), 32'd1);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    checkOutput("ovr_clear", 32'(bus.Overrun), 32'd0);

    // Mid-stream reset: HOLD active, three words queued, overrun pending
    applyStimulus(1'b1, 16'h0001, 1'b0, 1'b1, 16'h0BEE, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h0002, 1'b0, 1'b1, 16'h0BAD, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h0003, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    bus.ExtInValid = 1'b0;
    checkOutput("pre_rst_count", 32'(bus.InCount), 32'd3);
    checkOutput("pre_rst_valid", 32'(bus.ExtOutValid), 32'd1);
    checkOutput("pre_rst_ovr",   32'(bus.Overrun), 32'd1);
    #2;
    Reset = 1'b0;
    #1;
    checkOutput("mid_rst_count", 32'(bus.InCount), 32'd0);
    checkOutput("mid_rst_valid", 32'(bus.ExtOutValid), 32'd0);
    checkOutput("mid_rst_data",  32'(bus.ExtOutData), 32'h0);
    checkOutput("mid_rst_ovr",   32'(bus.Overrun), 32'd0);
    checkOutput("mid_rst_ur",    32'(bus.Underrun), 32'd0);
    checkOutput("mid_rst_ioin",  32'(bus.IOIn), 32'h0);
    idle();
    Reset = 1'b1;
    step();
    checkOutput("post_rst_inready", 32'(bus.ExtInReady), 32'd1);
    checkOutput("post_rst_count",   32'(bus.InCount), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
